// File: rtl/mips_defs.sv
// ----------------------------------------------------------------------------
// mips_defs
//   Shared definitions for the MIPS datapath register file.
//   Holds the register address/data widths and the architecturally special
//   register numbers ($0 hard-wired zero, $31 JAL link target).
// ----------------------------------------------------------------------------
package mips_defs;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage : mips_defs

// File: rtl/reg_addr_decoder_5to32.sv
// ----------------------------------------------------------------------------
// reg_addr_decoder_5to32
//   Decodes a register address into one-hot per-register write enables.
//   Bit 0 is tied low because $0 is never written.
// Ports
//   addr    in   ADDR_W        register address (RegDst select output)
//   en      in   1             write enable (RegWrite)
//   onehot  out  2**ADDR_W     onehot[i] = en && addr == i, onehot[0] = 0
// ----------------------------------------------------------------------------
module reg_addr_decoder_5to32
    import mips_defs::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic                   en,
    output logic [(1<<ADDR_W)-1:0] onehot
);

    localparam int DEPTH = 1 << ADDR_W;

    // NOTE: every bit is assigned a default before the loop so that no
    // path through the block leaves onehot unassigned (no latch inferred).
    always_comb begin
        onehot = '0;
        for (int i = 1; i < DEPTH; i++) begin
            onehot[i] = en && (addr == ADDR_W'(i));
        end
    end

endmodule : reg_addr_decoder_5to32

// File: rtl/reg_file_32x32.sv
// ----------------------------------------------------------------------------
// reg_file_32x32
//   MIPS general-purpose register file: 32 x DATA_W, two combinational read
//   ports, one synchronous write port and a combinational debug read port.
//   $0 reads as zero and has no storage. With BYPASS_EN set, a read of the
//   register being written this cycle returns the incoming wdata so decode
//   and write-back can share a cycle. The debug port never bypasses.
// Ports
//   clk       in   1       rising-edge clock
//   reset     in   1       synchronous active-high clear of all registers
//   raddr1    in   ADDR_W  read port 1 address (rs)
//   rdata1    out  DATA_W  read port 1 data
//   raddr2    in   ADDR_W  read port 2 address (rt)
//   rdata2    out  DATA_W  read port 2 data
//   we        in   1       write enable (RegWrite)
//   waddr     in   ADDR_W  write address
//   wdata     in   DATA_W  write data
//   dbg_addr  in   ADDR_W  debug read address
//   dbg_data  out  DATA_W  debug read data (no bypass)
// ----------------------------------------------------------------------------
module reg_file_32x32
    import mips_defs::*;
#(
    parameter int DATA_W    = REG_DATA_W,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]  wr_en;
    logic [DATA_W-1:0] regs_q [1:DEPTH-1];
    logic [DATA_W-1:0] regs_d [1:DEPTH-1];
    logic              bypass1;
    logic              bypass2;

    reg_addr_decoder_5to32 #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .addr   (waddr),
        .en     (we),
        .onehot (wr_en)
    );

    // Next state: only the register selected by the decoder takes wdata.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            regs_d[i] = wr_en[i] ? wdata : regs_q[i];
        end
    end

    // NOTE: the storage is plain flops rather than a RAM macro, so it can be
    // cleared by reset; reset is checked first so it wins over a write.
    // Sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // wr_en[0] is always 0, so forwarding can never target $0.
    assign bypass1 = BYPASS_EN && !reset && wr_en[raddr1];
    assign bypass2 = BYPASS_EN && !reset && wr_en[raddr2];

    always_comb begin
        rdata1 = '0;
        if (bypass1) begin
            rdata1 = wdata;
        end else if (raddr1 != REG_ZERO) begin
            rdata1 = regs_q[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (bypass2) begin
            rdata2 = wdata;
        end else if (raddr2 != REG_ZERO) begin
            rdata2 = regs_q[raddr2];
        end
    end

    always_comb begin
        dbg_data = '0;
        if (dbg_addr != REG_ZERO) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

    // An unknown we may only ever disturb the addressed register; every other
    // register must hold across the edge.
    for (genvar g = 1; g < DEPTH; g++) begin : g_hold_chk
        a_hold : assert property (@(posedge clk)
            (!reset && !$isunknown(waddr) && waddr != ADDR_W'(g))
            |=> (regs_q[g] == $past(regs_q[g])));
    end

endmodule : reg_file_32x32

// File: tb/tb_reg_file_32x32.sv
// ----------------------------------------------------------------------------
// tb_reg_file_32x32
//   Directed self-checking bench for reg_file_32x32 (BYPASS_EN = 1).
// ----------------------------------------------------------------------------
module tb_reg_file_32x32;

    logic        clk;
    logic        reset;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int passed = 0;
    int total  = 0;

    reg_file_32x32 #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .BYPASS_EN (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .raddr1   (raddr1),
        .rdata1   (rdata1),
        .raddr2   (raddr2),
        .rdata2   (rdata2),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; inputs are then changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0; waddr = 5'd0; wdata = '0;
    endtask

    task automatic test_reset();
        write_reg(5'd5, 32'hDEADBEEF);
        raddr1 = 5'd5; #1;
        total++;
        if (rdata1 !== 32'hDEADBEEF) $display("FAIL reset_prewrite got=%h exp=%h", rdata1, 32'hDEADBEEF);
        else passed++;
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL reset_clear_r5 got=%h exp=%h", rdata1, 32'h0);
        else passed++;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); dbg_addr = 5'(a); #1;
            total++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || dbg_data !== 32'h0) begin
                $display("FAIL reset_sweep a=%0d got r1=%h r2=%h dbg=%h exp=0", a, rdata1, rdata2, dbg_data);
            end else passed++;
        end
    endtask

    task automatic test_basic_rw();
        write_reg(5'd8, 32'h12345678);
        raddr1 = 5'd8; raddr2 = 5'd8; dbg_addr = 5'd8; #1;
        total++;
        if (rdata1 !== 32'h12345678) $display("FAIL basic_r1 got=%h exp=%h", rdata1, 32'h12345678);
        else passed++;
        total++;
        if (rdata2 !== 32'h12345678) $display("FAIL basic_r2 got=%h exp=%h", rdata2, 32'h12345678);
        else passed++;
        total++;
        if (dbg_data !== 32'h12345678) $display("FAIL basic_dbg got=%h exp=%h", dbg_data, 32'h12345678);
        else passed++;
        // Zero-latency read: an address change is seen without a clock edge.
        raddr1 = 5'd5; #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL basic_addr_change got=%h exp=%h", rdata1, 32'h0);
        else passed++;
    endtask

    task automatic test_zero_reg();
        raddr1 = 5'd0;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL zero_pre_edge got=%h exp=%h", rdata1, 32'h0);
        else passed++;
        total++;
        if (dut.u_dec.onehot !== 32'h0) $display("FAIL zero_onehot got=%h exp=%h", dut.u_dec.onehot, 32'h0);
        else passed++;
        tick();
        we = 1'b0; #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL zero_post_edge got=%h exp=%h", rdata1, 32'h0);
        else passed++;
    endtask

    task automatic test_bypass();
        write_reg(5'd9, 32'h00001111);
        write_reg(5'd8, 32'h00000808);
        raddr1 = 5'd9; raddr2 = 5'd8; dbg_addr = 5'd9;
        we = 1'b1; waddr = 5'd9; wdata = 32'h00002222; #1;
        total++;
        if (rdata1 !== 32'h00002222) $display("FAIL bypass_r1 got=%h exp=%h", rdata1, 32'h00002222);
        else passed++;
        total++;
        if (dbg_data !== 32'h00001111) $display("FAIL bypass_dbg got=%h exp=%h", dbg_data, 32'h00001111);
        else passed++;
        total++;
        if (rdata2 !== 32'h00000808) $display("FAIL bypass_other_addr got=%h exp=%h", rdata2, 32'h00000808);
        else passed++;
        // Both ports on the written register forward together.
        raddr2 = 5'd9; #1;
        total++;
        if (rdata2 !== 32'h00002222) $display("FAIL bypass_r2 got=%h exp=%h", rdata2, 32'h00002222);
        else passed++;
        tick();
        we = 1'b0; #1;
        total++;
        if (dbg_data !== 32'h00002222) $display("FAIL bypass_committed got=%h exp=%h", dbg_data, 32'h00002222);
        else passed++;
    endtask

    task automatic test_reset_vs_write();
        write_reg(5'd3, 32'hA5A5A5A5);
        raddr1 = 5'd3;
        reset = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h5A5A5A5A; #1;
        total++;
        if (rdata1 !== 32'hA5A5A5A5) $display("FAIL rst_wr_no_bypass got=%h exp=%h", rdata1, 32'hA5A5A5A5);
        else passed++;
        tick();
        reset = 1'b0; we = 1'b0; #1;
        total++;
        if (rdata1 !== 32'h0) $display("FAIL rst_wr_cleared got=%h exp=%h", rdata1, 32'h0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        write_reg(5'd10, 32'hAAAA0001);
        write_reg(5'd11, 32'hBBBB0002);
        // Holding we over two edges rewrites the same register; last value wins.
        we = 1'b1; waddr = 5'd12; wdata = 32'hCCCC0003;
        tick();
        wdata = 32'hDDDD0004;
        tick();
        we = 1'b0;
        raddr1 = 5'd10; raddr2 = 5'd11; dbg_addr = 5'd12; #1;
        total++;
        if (rdata1 !== 32'hAAAA0001 || rdata2 !== 32'hBBBB0002 || dbg_data !== 32'hDDDD0004) begin
            $display("FAIL back_to_back got r1=%h r2=%h dbg=%h exp=aaaa0001/bbbb0002/dddd0004", rdata1, rdata2, dbg_data);
        end else passed++;
    endtask

    task automatic test_sweep();
        logic [31:0] exp;
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'(i) * 32'h01010101);
        end
        for (int a = 0; a < 32; a++) begin
            exp = 32'(a) * 32'h01010101;
            raddr1 = 5'(a); raddr2 = 5'(a); dbg_addr = 5'(a); #1;
            total++;
            if (rdata1 !== exp || rdata2 !== exp || dbg_data !== exp) begin
                $display("FAIL sweep a=%0d got r1=%h r2=%h dbg=%h exp=%h", a, rdata1, rdata2, dbg_data, exp);
            end else passed++;
        end
        raddr1 = 5'd31; #1;
        total++;
        if (rdata1 !== 32'h1F1F1F1F) $display("FAIL sweep_ra got=%h exp=%h", rdata1, 32'h1F1F1F1F);
        else passed++;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; dbg_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_basic_rw();
        test_zero_reg();
        test_bypass();
        test_reset_vs_write();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_reg_file_32x32
